// File: rtl/operand_pipe_pkg.sv
// operand_pipe_pkg: shared defaults and entry layout for the operand pipe register.
package operand_pipe_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_NCH   = 2;
    localparam int DEF_AW    = 3;

    typedef struct packed {
        logic [DEF_NCH-1:0][DEF_WIDTH-1:0] data;
        logic [DEF_NCH-1:0][DEF_AW-1:0]    addr;
    } entry_t;
endpackage

// File: rtl/operand_pipe_reg_entry.sv
// operand_entry: one operand slot with load, per-channel writeback patch and clear.
module operand_entry
    import operand_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int AW    = DEF_AW
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_flush,
    input  logic                 i_load,
    input  logic                 i_valid_d,
    input  logic [NCH*WIDTH-1:0] i_load_data,
    input  logic [NCH*AW-1:0]    i_load_addr,
    input  logic                 i_wb_en,
    input  logic [AW-1:0]        i_wb_addr,
    input  logic [WIDTH-1:0]     i_wb_data,
    output logic                 o_valid,
    output logic [NCH*WIDTH-1:0] o_data,
    output logic [NCH*AW-1:0]    o_addr
);
    logic                 r_valid;
    logic [NCH*WIDTH-1:0] r_data;
    logic [NCH*AW-1:0]    r_addr;
    logic [NCH*WIDTH-1:0] w_data_d;
    logic [NCH*AW-1:0]    w_addr_d;

    // The same compare serves forwarding on load and patching while held.
    always_comb begin
        w_addr_d = i_load ? i_load_addr : r_addr;
        w_data_d = i_load ? i_load_data : r_data;
        for (int c = 0; c < NCH; c++)
            if (i_wb_en && (i_load || r_valid) && w_addr_d[c*AW +: AW] == i_wb_addr)
                w_data_d[c*WIDTH +: WIDTH] = i_wb_data;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
        end else begin
            r_valid <= i_valid_d;
            if (!i_flush) begin
                r_data <= w_data_d;
                r_addr <= w_addr_d;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_addr  = r_addr;
endmodule

// File: rtl/operand_pipe_reg.sv
// operand_pipe_reg: 2-entry in-order operand buffer between register-file read and the ALU.
module operand_pipe_reg
    import operand_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int AW    = DEF_AW
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_p3,
    input  logic                 i_flush,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [NCH*AW-1:0]    i_src_addr,
    input  logic [NCH*WIDTH-1:0] i_src_data,
    input  logic                 i_wb_en,
    input  logic [AW-1:0]        i_wb_addr,
    input  logic [WIDTH-1:0]     i_wb_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [NCH*WIDTH-1:0] o_out_data,
    output logic [1:0]           o_occupancy
);
    // Index 0 is the main entry facing the ALU, index 1 the skid entry.
    logic                 w_valid   [2];
    logic [NCH*WIDTH-1:0] w_data    [2];
    logic [NCH*AW-1:0]    w_addr    [2];
    logic                 w_load    [2];
    logic                 w_vd      [2];
    logic [NCH*WIDTH-1:0] w_ld_data [2];
    logic [NCH*AW-1:0]    w_ld_addr [2];
    logic                 w_accept;
    logic                 w_drain;
    logic [1:0]           r_occupancy;

    always_comb begin
        o_in_ready   = !w_valid[1] && !i_flush;
        w_accept     = i_p3 && i_in_valid && o_in_ready;
        w_drain      = w_valid[0] && i_out_ready;
        w_load[0]    = !i_flush && (w_valid[1] ? w_drain : w_accept && (!w_valid[0] || w_drain));
        w_load[1]    = w_accept && w_valid[0] && !w_drain;
        w_vd[0]      = !i_flush && (w_load[0] || (w_valid[0] && !w_drain));
        w_vd[1]      = !i_flush && (w_load[1] || (w_valid[1] && !w_drain));
        w_ld_data[0] = w_valid[1] ? w_data[1] : i_src_data;
        w_ld_addr[0] = w_valid[1] ? w_addr[1] : i_src_addr;
        w_ld_data[1] = i_src_data;
        w_ld_addr[1] = i_src_addr;
    end

    for (genvar e = 0; e < 2; e++) begin : g_entry
        operand_entry #(.WIDTH(WIDTH), .NCH(NCH), .AW(AW)) u_entry (
            .i_clock     (i_clock),
            .i_reset_n   (i_reset_n),
            .i_flush     (i_flush),
            .i_load      (w_load[e]),
            .i_valid_d   (w_vd[e]),
            .i_load_data (w_ld_data[e]),
            .i_load_addr (w_ld_addr[e]),
            .i_wb_en     (i_wb_en),
            .i_wb_addr   (i_wb_addr),
            .i_wb_data   (i_wb_data),
            .o_valid     (w_valid[e]),
            .o_data      (w_data[e]),
            .o_addr      (w_addr[e])
        );
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_occupancy <= 2'd0;
        else            r_occupancy <= {1'b0, w_vd[0]} + {1'b0, w_vd[1]};
    end

    assign o_out_valid = w_valid[0];
    assign o_out_data  = w_data[0];
    assign o_occupancy = r_occupancy;
endmodule

// File: tb/tb_operand_pipe_reg.sv
// tb_operand_pipe_reg: directed vector table plus an asynchronous mid-traffic reset sequence.
module tb_operand_pipe_reg;
    logic        clk = 1'b0;
    logic        rst_n, p3, flush, in_valid, in_ready, wb_en, out_valid, out_ready;
    logic [5:0]  src_addr;
    logic [31:0] src_data, out_data;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [1:0]  occ;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic        p3, iv, fl, ordy, wbe;
        logic [5:0]  sa;
        logic [31:0] sd;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        e_rdy, e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t v[18];

    operand_pipe_reg dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_p3        (p3),
        .i_flush     (flush),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_src_addr  (src_addr),
        .i_src_data  (src_data),
        .i_wb_en     (wb_en),
        .i_wb_addr   (wb_addr),
        .i_wb_data   (wb_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_occupancy (occ)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic p, iv, fl, ordy, logic [5:0] sa, logic [31:0] sd,
                                logic wbe, logic [2:0] wa, logic [15:0] wd,
                                logic er, eov, logic [31:0] eod, logic [1:0] eocc);
        vec_t t;
        t.p3 = p; t.iv = iv; t.fl = fl; t.ordy = ordy; t.sa = sa; t.sd = sd;
        t.wbe = wbe; t.wa = wa; t.wd = wd;
        t.e_rdy = er; t.e_ov = eov; t.e_od = eod; t.e_occ = eocc;
        return t;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t t);
        p3 = t.p3; in_valid = t.iv; flush = t.fl; out_ready = t.ordy;
        src_addr = t.sa; src_data = t.sd; wb_en = t.wbe; wb_addr = t.wa; wb_data = t.wd;
    endtask

    initial begin
        v[0]  = mk(0,0,0,1, 6'o00, 32'h0000_0000, 0,0,16'h0000,    1,0,32'h0000_0000,0);
        v[1]  = mk(0,1,0,1, 6'o35, 32'h1111_2222, 0,0,16'h0000,    1,0,32'h0000_0000,0);
        v[2]  = mk(1,1,0,1, 6'o35, 32'h1111_2222, 0,0,16'h0000,    1,1,32'h1111_2222,1);
        v[3]  = mk(1,1,0,1, 6'o35, 32'h1111_2222, 1,5,16'hBEEF,    1,1,32'h1111_BEEF,1);
        v[4]  = mk(0,0,0,1, 6'o00, 32'h0000_0000, 0,0,16'h0000,    1,0,32'h1111_BEEF,0);
        v[5]  = mk(1,1,0,0, 6'o13, 32'hA001_A000, 0,0,16'h0000,    1,1,32'hA001_A000,1);
        v[6]  = mk(1,1,0,0, 6'o32, 32'hB001_B000, 0,0,16'h0000,    1,1,32'hA001_A000,2);
        v[7]  = mk(1,1,0,0, 6'o44, 32'hC001_C000, 0,0,16'h0000,    0,1,32'hA001_A000,2);
        v[8]  = mk(0,0,0,0, 6'o00, 32'h0000_0000, 1,3,16'h00AA,    0,1,32'hA001_00AA,2);
        v[9]  = mk(1,1,0,1, 6'o44, 32'hC001_C000, 0,0,16'h0000,    0,1,32'h00AA_B000,1);
        v[10] = mk(0,0,0,1, 6'o00, 32'h0000_0000, 0,0,16'h0000,    1,0,32'h00AA_B000,0);
        v[11] = mk(1,1,0,0, 6'o01, 32'hD001_D000, 0,0,16'h0000,    1,1,32'hD001_D000,1);
        v[12] = mk(1,1,1,1, 6'o22, 32'hE001_E000, 1,1,16'h1234,    0,0,32'hD001_D000,0);
        v[13] = mk(0,0,0,1, 6'o00, 32'h0000_0000, 0,0,16'h0000,    1,0,32'hD001_D000,0);
        v[14] = mk(1,1,0,0, 6'o67, 32'hF001_F000, 0,0,16'h0000,    1,1,32'hF001_F000,1);
        v[15] = mk(1,1,0,0, 6'o66, 32'h6001_6000, 0,0,16'h0000,    1,1,32'hF001_F000,2);
        v[16] = mk(0,0,0,1, 6'o00, 32'h0000_0000, 1,6,16'h5555,    0,1,32'h5555_5555,1);
        v[17] = mk(0,0,0,1, 6'o00, 32'h0000_0000, 0,0,16'h0000,    1,0,32'h5555_5555,0);

        rst_n = 1'b0;
        drive(v[0]);
        #12;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_data", out_data, 32'd0);
        chk("reset occupancy", {30'd0, occ}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(v[i]);
            #1;
            chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, {31'd0, v[i].e_rdy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, v[i].e_ov});
            chk($sformatf("v%0d out_data", i), out_data, v[i].e_od);
            chk($sformatf("v%0d occupancy", i), {30'd0, occ}, {30'd0, v[i].e_occ});
        end

        @(negedge clk);
        drive(mk(1,1,0,0, 6'o12, 32'h7001_7000, 0,0,16'h0000, 0,0,0,0));
        @(negedge clk);
        src_data = 32'h8001_8000;
        @(posedge clk);
        #1;
        chk("fill occupancy", {30'd0, occ}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async out_valid", {31'd0, out_valid}, 32'd0);
        chk("async out_data", out_data, 32'd0);
        chk("async occupancy", {30'd0, occ}, 32'd0);
        chk("async in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        drive(v[0]);
        rst_n = 1'b1;
        #1;
        chk("release in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("release out_valid", {31'd0, out_valid}, 32'd0);
        chk("release occupancy", {30'd0, occ}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/operand_pipe_reg.md
Name: operand_pipe_reg

Overview:
Parametrised successor to the single-channel regfile-to-ALU operand latch. It captures NCH operands of WIDTH bits from the register file during the p3 load phase. Operands are held in a 2-entry in-order buffer with a valid/ready handshake toward the ALU, so a downstream stall never drops data. It adds writeback forwarding at capture, in-place patching of held entries, and a synchronous flush. It sits between register-file read and the ALU.

Parameters:
WIDTH, 16, bits per operand channel
NCH, 2, number of operand channels
AW, 3, register address width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
p3  in  1  load phase enable; capture is permitted only when 1
flush  in  1  synchronous pipeline flush
in_valid  in  1  upstream offers an operand set
in_ready  out  1  block can accept; combinational = !skid_valid && !flush
src_addr  in  NCH*AW  source register address per channel, channel c at [c*AW +: AW]
src_data  in  NCH*WIDTH  register-file read data per channel
wb_en  in  1  writeback strobe
wb_addr  in  AW  writeback register address
wb_data  in  WIDTH  writeback data
out_valid  out  1  main entry holds a valid operand set
out_ready  in  1  ALU consumes the main entry
out_data  out  NCH*WIDTH  operands of the main entry
occupancy  out  2  number of valid entries, 0..2

Behaviour:
- Reset (reset==0, asynchronous): main_valid=0, skid_valid=0, out_data=0, all stored addresses=0, occupancy=0. in_ready reads 1 once flush=0.
- accept = p3 && in_valid && in_ready. drain = out_valid && out_ready.
- Forward at capture: captured channel c = (wb_en && wb_addr==src_addr[c]) ? wb_data : src_data[c]. src_addr[c] is stored with the entry.
- Patch while held: on any cycle with wb_en, every valid entry (main and skid) whose stored addr[c]==wb_addr takes wb_data for channel c on that edge. Patch is per channel; several channels may match at once.
- Ordering is strict FIFO. The skid entry is only ever written when main is valid and not draining.
- Edge update, flush==0:
  - empty, accept: load main.
  - main only, accept, no drain: load skid.
  - main only, accept + drain: main <= input.
  - main only, drain only: main_valid <= 0. out_data keeps its last value.
  - both full, drain: main <= skid (patched if wb matches), skid_valid <= 0. in_ready is 0 this cycle, so no accept.
  - p3==0: no capture, even if in_valid. Patching and draining still occur.
- Flush (flush==1): on the edge, main_valid=0 and skid_valid=0. Flush has priority over accept, drain and patch. out_data is left unchanged. in_ready=0 during the flush cycle.
- out_data is the main entry's data including patches. It is registered; no combinational path from wb_* to out_data.
- Latency: 1 clock from accepted capture to out_valid.
- A forwarded value and a simultaneous patch on the same edge use the same wb_data, so no conflict arises.
- occupancy = main_valid + skid_valid, registered.
- Reset asserted mid-operation discards every entry immediately. No partial state survives.

Decomposition:
- Shared package operand_pipe_pkg holds the defaults (WIDTH=16, NCH=2, AW=3) and the entry struct typedef: data[NCH][WIDTH], addr[NCH][AW].
- One sub-module, operand_entry: a single storage slot with load, patch (wb compare per channel) and clear. It is instantiated twice (main, skid). Top level holds the FIFO control.

Test Plan:
1. Reset mid-traffic: both entries full, pull reset=0 asynchronously between edges -> out_valid=0, out_data=0, occupancy=0 immediately; in_ready=1 after release.
2. Basic capture: p3=1, in_valid=1, src_addr={3,5}, src_data={16'h1111,16'h2222}, out_ready=1 -> next edge out_valid=1, out_data={16'h1111,16'h2222}; with p3=0 the same stimulus is not captured.
3. Forward at capture: src_addr={3,5}, wb_en=1, wb_addr=5, wb_data=16'hBEEF -> captured {16'h1111,16'hBEEF}.
4. Stall + skid: out_ready=0, two accepts (A then B) -> occupancy=2, in_ready=0, third offer not taken. Release out_ready -> A then B on consecutive cycles, in order.
5. Patch held entries: entries A (addr ch0=3) and B (addr ch1=3) held; wb_en=1, wb_addr=3, wb_data=16'h00AA -> A ch0 and B ch1 read 16'h00AA when drained; other channels unchanged.
6. Flush priority: occupancy=1, flush=1 together with accept and drain -> next edge occupancy=0, out_valid=0, in_ready=0 during the flush cycle, input not captured.
